// File: rtl/digit_serial_add_sub_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | digit_serial_add_sub_if : digit-serial operand and result stream bundle    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface digit_serial_add_sub_if #(
   parameter int DIGIT_W = 1
);
   logic               in_valid;
   logic               in_first;
   logic               sub;
   logic [DIGIT_W-1:0] a;
   logic [DIGIT_W-1:0] b;
   logic               out_valid;
   logic [DIGIT_W-1:0] sum;
   logic               out_last;
   logic               carry_out;
   logic               overflow;

   modport master (
      output in_valid, in_first, sub, a, b,
      input  out_valid, sum, out_last, carry_out, overflow
   );

   modport slave (
      input  in_valid, in_first, sub, a, b,
      output out_valid, sum, out_last, carry_out, overflow
   );
endinterface
`default_nettype wire

// File: rtl/digit_serial_add_sub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | digit_serial_add_sub : framed LSB-first digit-serial adder/subtractor      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module digit_serial_add_sub #(
   parameter int DIGIT_W     = 1,
   parameter int WORD_DIGITS = 16
) (
   input  wire                         clk,
   input  wire                         rst,
   digit_serial_add_sub_if.slave       bus
);
   localparam int CNT_W = $clog2(WORD_DIGITS);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t             r_state;
   logic               r_carry;
   logic               r_mode;
   logic [CNT_W-1:0]   r_count;

   logic               w_mode;
   logic               w_cin;
   logic [DIGIT_W-1:0] w_b_eff;
   logic [DIGIT_W:0]   w_ext;
   logic [DIGIT_W-1:0] w_s;
   logic               w_c_next;
   logic               w_top_cin;
   logic               w_last;

   // A first digit takes its mode (and carry-in) straight from the sub input
   assign w_mode    = bus.in_first ? bus.sub : r_mode;
   assign w_cin     = bus.in_first ? bus.sub : r_carry;
   assign w_b_eff   = w_mode ? ~bus.b : bus.b;
   assign w_ext     = {1'b0, bus.a} + {1'b0, w_b_eff} + {{DIGIT_W{1'b0}}, w_cin};
   assign w_s       = w_ext[DIGIT_W-1:0];
   assign w_c_next  = w_ext[DIGIT_W];
   // Carry into the top bit recovered from its sum bit, valid for any DIGIT_W
   assign w_top_cin = w_s[DIGIT_W-1] ^ bus.a[DIGIT_W-1] ^ w_b_eff[DIGIT_W-1];
   assign w_last    = (r_count == CNT_W'(WORD_DIGITS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_carry       <= 1'b0;
         r_mode        <= 1'b0;
         r_count       <= '0;
         bus.out_valid <= 1'b0;
         bus.sum       <= '0;
         bus.out_last  <= 1'b0;
         bus.carry_out <= 1'b0;
         bus.overflow  <= 1'b0;
      end else begin
         bus.out_valid <= 1'b0;
         bus.out_last  <= 1'b0;
         bus.carry_out <= 1'b0;
         bus.overflow  <= 1'b0;
         if (bus.in_valid && bus.in_first) begin
            // Also aborts any word in flight
            bus.out_valid <= 1'b1;
            bus.sum       <= w_s;
            r_carry       <= w_c_next;
            r_mode        <= bus.sub;
            r_count       <= CNT_W'(1);
            r_state       <= BUSY;
         end else if (bus.in_valid && r_state == BUSY) begin
            bus.out_valid <= 1'b1;
            bus.sum       <= w_s;
            r_carry       <= w_c_next;
            if (w_last) begin
               bus.out_last  <= 1'b1;
               bus.carry_out <= w_c_next;
               bus.overflow  <= w_top_cin ^ w_c_next;
               r_count       <= '0;
               r_state       <= IDLE;
            end else begin
               r_count <= r_count + CNT_W'(1);
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_digit_serial_add_sub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_digit_serial_add_sub : two configurations against a word-level model    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_digit_serial_add_sub;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   digit_serial_add_sub_if #(.DIGIT_W(1)) if1 ();
   digit_serial_add_sub_if #(.DIGIT_W(4)) if2 ();

   digit_serial_add_sub #(.DIGIT_W(1), .WORD_DIGITS(4)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1.slave)
   );

   digit_serial_add_sub #(.DIGIT_W(4), .WORD_DIGITS(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (if2.slave)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Whole-word reference: two's-complement add or subtract of n-bit words
   task automatic ref_word(input logic [63:0] aw, input logic [63:0] bw, input logic s,
                           input int n, output logic [63:0] sm, output logic c,
                           output logic ov);
      logic [64:0] r;
      logic [63:0] mask;
      logic [63:0] beff;
      mask = (64'd1 << n) - 64'd1;
      beff = s ? (~bw & mask) : (bw & mask);
      r    = {1'b0, aw & mask} + {1'b0, beff} + {64'd0, s};
      sm   = r[63:0] & mask;
      c    = r[n];
      ov   = (aw[n-1] == beff[n-1]) && (sm[n-1] != aw[n-1]);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int u, input logic v, input logic f, input logic s,
                        input logic [3:0] da, input logic [3:0] db);
      if1.in_valid = 1'b0;
      if2.in_valid = 1'b0;
      if (u == 1) begin
         if1.in_valid = v; if1.in_first = f; if1.sub = s; if1.a = da[0]; if1.b = db[0];
      end else begin
         if2.in_valid = v; if2.in_first = f; if2.sub = s; if2.a = da; if2.b = db;
      end
   endtask

   task automatic check_out(input int u, input string tag, input logic ev, input logic [3:0] es,
                            input logic el, input logic ec, input logic eo, input logic chk_sum);
      logic       ov, ol, oc, of;
      logic [3:0] os;
      if (u == 1) begin
         ov = if1.out_valid; os = {3'b000, if1.sum}; ol = if1.out_last;
         oc = if1.carry_out; of = if1.overflow;
      end else begin
         ov = if2.out_valid; os = if2.sum; ol = if2.out_last;
         oc = if2.carry_out; of = if2.overflow;
      end
      chk({tag, "_valid"}, 64'(ov), 64'(ev));
      if (chk_sum) chk({tag, "_sum"}, 64'(os), 64'(es));
      chk({tag, "_last"}, 64'(ol), 64'(el));
      chk({tag, "_carry"}, 64'(oc), 64'(ec));
      chk({tag, "_ovf"}, 64'(of), 64'(eo));
   endtask

   task automatic idle(input int u);
      drive(u, 1'b0, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
      step();
      check_out(u, "idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Streams ndig digits of a word; ndig < word length models an aborted word
   task automatic word(input int u, input logic [63:0] aw, input logic [63:0] bw, input logic s,
                       input int ndig, input int gap_at, input int gap_len);
      int          dw, wd;
      logic [63:0] sm;
      logic        c, o, last;
      logic [3:0]  dmask, da, db, ds;
      dw    = (u == 1) ? 1 : 4;
      wd    = (u == 1) ? 4 : 2;
      dmask = (u == 1) ? 4'h1 : 4'hF;
      ref_word(aw, bw, s, dw * wd, sm, c, o);
      for (int d = 0; d < ndig; d++) begin
         if (d == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               drive(u, 1'b0, 1'b0, 1'($urandom), 4'($urandom), 4'($urandom));
               step();
               check_out(u, "gap", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
         end
         da = 4'(aw >> (d * dw)) & dmask;
         db = 4'(bw >> (d * dw)) & dmask;
         ds = 4'(sm >> (d * dw)) & dmask;
         drive(u, 1'b1, d == 0, (d == 0) ? s : 1'($urandom), da, db);
         step();
         last = (d == wd - 1);
         check_out(u, "digit", 1'b1, ds, last, last & c, last & o, 1'b1);
      end
   endtask

   initial begin
      int          u, ndig, gap_at, gap_len;
      logic [63:0] aw, bw;
      logic        s;

      rst = 1'b1;
      drive(1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      step();
      step();
      check_out(1, "reset1", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_out(2, "reset2", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      idle(1);

      // Digits without a first digit are ignored from IDLE
      drive(1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1);
      step();
      check_out(1, "nofirst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      word(1, 64'd3, 64'd5, 1'b0, 4, -1, 0);
      idle(1);
      word(1, 64'd5, 64'd3, 1'b1, 4, -1, 0);
      word(1, 64'd3, 64'd5, 1'b1, 4, -1, 0);
      idle(1);
      word(1, 64'd3, 64'd5, 1'b0, 4, 2, 2);
      word(1, 64'd6, 64'd7, 1'b0, 2, -1, 0);
      word(1, 64'd9, 64'd4, 1'b1, 4, -1, 0);
      word(2, 64'h7F, 64'h01, 1'b0, 2, -1, 0);
      word(2, 64'hFF, 64'h01, 1'b0, 2, -1, 0);
      word(2, 64'h80, 64'h01, 1'b1, 2, -1, 0);
      idle(2);

      // Reset mid-word, then orphan digits, then a clean word
      drive(1, 1'b1, 1'b1, 1'b0, 4'd1, 4'd1);
      step();
      drive(1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_out(1, "rst_mid", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         drive(1, 1'b1, 1'b0, 1'($urandom), 4'($urandom), 4'($urandom));
         step();
         check_out(1, "post_rst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      word(1, 64'd12, 64'd7, 1'b1, 4, -1, 0);

      for (int it = 0; it < 40; it++) begin
         u       = ($urandom_range(0, 1) == 0) ? 1 : 2;
         aw      = 64'($urandom);
         bw      = 64'($urandom);
         s       = 1'($urandom);
         ndig    = (u == 1) ? 4 : 2;
         if ($urandom_range(0, 5) == 0) ndig = $urandom_range(1, ndig - 1);
         gap_at  = $urandom_range(1, ndig + 1);
         gap_len = $urandom_range(1, 3);
         word(u, aw, bw, s, ndig, gap_at, gap_len);
         if ($urandom_range(0, 2) == 0) idle(u);
      end
      idle(1);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
